// File: rtl/vx_rr_lock_arbiter.sv
// Registered round-robin arbiter: NUM_REQS valid/ready streams share one output register,
// with an optional grant lock that holds a requester until the last beat of its packet.
module vx_rr_lock_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter bit LOCK_PKT = 1'b1,
    localparam int LN      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       in_valid,
    input  logic [NUM_REQS*DATAW-1:0] in_data,
    input  logic [NUM_REQS-1:0]       in_last,
    output logic [NUM_REQS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic [LN-1:0]             out_sel,
    output logic                      out_last,
    input  logic                      out_ready
);

    logic [LN-1:0]    last_ptr;
    logic [LN-1:0]    lock_idx;
    logic             locked;
    logic [LN-1:0]    grant_idx;
    logic             grant_valid;
    logic [DATAW-1:0] grant_data;
    logic             grant_last;
    logic             stage_ready;
    logic             fire;

    // Descending scans leave the lowest matching index; the second scan only
    // overrides the first when some requester sits above the last winner.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (locked) begin
            grant_idx   = lock_idx;
            grant_valid = in_valid[lock_idx];
        end else begin
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_valid = 1'b1;
                    grant_idx   = LN'(i);
                end
            end
            for (int i = NUM_REQS - 1; i >= 0; i--) begin
                if (in_valid[i] && (LN'(i) > last_ptr)) begin
                    grant_idx = LN'(i);
                end
            end
        end
    end

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (LN'(i) == grant_idx) begin
                grant_data = in_data[i*DATAW +: DATAW];
                grant_last = in_last[i];
            end
        end
    end

    assign stage_ready = !out_valid || out_ready;
    assign fire        = grant_valid && stage_ready;

    // Reset gates the ready path so nothing appears accepted while state is cleared.
    always_comb begin
        in_ready = '0;
        if (fire && reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (LN'(i) == grant_idx) begin
                    in_ready[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            last_ptr  <= LN'(NUM_REQS - 1);
            locked    <= 1'b0;
            lock_idx  <= '0;
        end else if (stage_ready) begin
            if (fire) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                out_last  <= grant_last;
                last_ptr  <= grant_idx;
                if (LOCK_PKT) begin
                    locked <= !grant_last;
                    if (!grant_last) begin
                        lock_idx <= grant_idx;
                    end
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vx_rr_lock_arbiter.sv
// Bench for vx_rr_lock_arbiter: three instances (4-way unlocked, 4-way locked, 1-way locked)
// driven with random traffic and compared every cycle against a circular-scan reference model.
module tb_vx_rr_lock_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [127:0] in_data;
    logic         out_ready;

    logic [3:0]   in_ready_a, in_ready_b;
    logic         out_valid_a, out_valid_b, out_last_a, out_last_b;
    logic [31:0]  out_data_a, out_data_b;
    logic [1:0]   out_sel_a, out_sel_b;

    logic         s_in_valid, s_in_last, s_out_ready;
    logic [7:0]   s_in_data;
    logic         s_in_ready, s_out_valid, s_out_last;
    logic [7:0]   s_out_data;
    logic         s_out_sel;

    int errors = 0;
    int checks = 0;

    vx_rr_lock_arbiter #(.NUM_REQS(4), .DATAW(32), .LOCK_PKT(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
        .out_sel(out_sel_a), .out_last(out_last_a), .out_ready(out_ready)
    );

    vx_rr_lock_arbiter #(.NUM_REQS(4), .DATAW(32), .LOCK_PKT(1'b1)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
        .out_sel(out_sel_b), .out_last(out_last_b), .out_ready(out_ready)
    );

    vx_rr_lock_arbiter #(.NUM_REQS(1), .DATAW(8), .LOCK_PKT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_sel(s_out_sel), .out_last(s_out_last), .out_ready(s_out_ready)
    );

    // Reference model state, one slot per instance; owner -1 means unlocked.
    int          num_reqs [3] = '{4, 4, 1};
    bit          lock_en  [3] = '{1'b0, 1'b1, 1'b1};
    int          m_last   [3];
    int          m_owner  [3];
    bit          m_valid  [3];
    bit          m_lastbit[3];
    logic [31:0] m_data   [3];
    int          m_sel    [3];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 3; m++) begin
            m_last[m]    = num_reqs[m] - 1;
            m_owner[m]   = -1;
            m_valid[m]   = 1'b0;
            m_lastbit[m] = 1'b0;
            m_data[m]    = '0;
            m_sel[m]     = 0;
        end
    endtask

    task automatic getInputs(input int m, output logic [3:0] v, output logic [3:0] l,
                             output logic [127:0] d, output logic orr);
        if (m < 2) begin
            v = in_valid; l = in_last; d = in_data; orr = out_ready;
        end else begin
            v = {3'b000, s_in_valid}; l = {3'b000, s_in_last};
            d = {120'd0, s_in_data}; orr = s_out_ready;
        end
    endtask

    function automatic logic [3:0] obsReady(input int m);
        if (m == 0) return in_ready_a;
        if (m == 1) return in_ready_b;
        return {3'b000, s_in_ready};
    endfunction

    // A locked owner is the only candidate; otherwise scan circularly from the slot after the last winner.
    function automatic int modelWinner(input int m, input logic [3:0] v);
        int idx;
        if (m_owner[m] >= 0) return v[m_owner[m]] ? m_owner[m] : -1;
        for (int k = 1; k <= num_reqs[m]; k++) begin
            idx = (m_last[m] + k) % num_reqs[m];
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic compareOutputs();
        checkOutput("a_valid", out_valid_a, m_valid[0]);
        checkOutput("a_data",  out_data_a,  m_data[0]);
        checkOutput("a_sel",   out_sel_a,   m_sel[0]);
        checkOutput("a_last",  out_last_a,  m_lastbit[0]);
        checkOutput("b_valid", out_valid_b, m_valid[1]);
        checkOutput("b_data",  out_data_b,  m_data[1]);
        checkOutput("b_sel",   out_sel_b,   m_sel[1]);
        checkOutput("b_last",  out_last_b,  m_lastbit[1]);
        checkOutput("s_valid", s_out_valid, m_valid[2]);
        checkOutput("s_data",  s_out_data,  m_data[2]);
        checkOutput("s_sel",   s_out_sel,   m_sel[2]);
        checkOutput("s_last",  s_out_last,  m_lastbit[2]);
    endtask

    // Drive one cycle of inputs, check ready against the model, then advance the model past the next edge.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] l, input logic [127:0] d,
                                 input logic orr, input logic sv, input logic sl,
                                 input logic [7:0] sd, input logic sorr);
        logic [3:0]   vv, ll, exp_rdy;
        logic [127:0] dd;
        logic         rr, sr;
        int           win;
        in_valid = v; in_last = l; in_data = d; out_ready = orr;
        s_in_valid = sv; s_in_last = sl; s_in_data = sd; s_out_ready = sorr;
        #1;
        for (int m = 0; m < 3; m++) begin
            getInputs(m, vv, ll, dd, rr);
            win     = modelWinner(m, vv);
            sr      = !m_valid[m] || rr;
            exp_rdy = (win >= 0 && sr) ? (4'b0001 << win) : 4'b0000;
            checkOutput($sformatf("rdy%0d", m), obsReady(m), exp_rdy);
            if (sr) begin
                if (win >= 0) begin
                    m_valid[m]   = 1'b1;
                    m_data[m]    = dd[win*32 +: 32];
                    m_sel[m]     = win;
                    m_lastbit[m] = ll[win];
                    m_last[m]    = win;
                    if (lock_en[m]) m_owner[m] = ll[win] ? -1 : win;
                end else begin
                    m_valid[m] = 1'b0;
                end
            end
        end
    endtask

    // Assert reset between edges with traffic pending and confirm outputs clear without a clock.
    task automatic doReset();
        in_valid = 4'hf; s_in_valid = 1'b1; out_ready = 1'b1; s_out_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_b_valid", out_valid_b, 0);
        checkOutput("rst_b_data",  out_data_b,  0);
        checkOutput("rst_b_sel",   out_sel_b,   0);
        checkOutput("rst_b_last",  out_last_b,  0);
        checkOutput("rst_a_valid", out_valid_a, 0);
        checkOutput("rst_s_valid", s_out_valid, 0);
        checkOutput("rst_rdy_a",   in_ready_a,  0);
        checkOutput("rst_rdy_b",   in_ready_b,  0);
        checkOutput("rst_rdy_s",   s_in_ready,  0);
        modelReset();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [127:0] rd;
        logic [3:0]   rl;
        bit           reset_done;
        reset = 1'b0;
        in_valid = 4'hf; in_last = 4'hf; in_data = '0; out_ready = 1'b1;
        s_in_valid = 1'b1; s_in_last = 1'b1; s_in_data = '0; s_out_ready = 1'b1;
        modelReset();
        #1;
        checkOutput("init_valid", out_valid_b, 0);
        checkOutput("init_rdy_a", in_ready_a, 0);
        checkOutput("init_rdy_s", s_in_ready, 0);
        #6 reset = 1'b1;

        // All requesters valid, single-beat packets: grant rotates 0,1,2,3,0...
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            compareOutputs();
            if (c >= 1) begin
                checkOutput("rot_valid", out_valid_a, 1);
                checkOutput("rot_sel",   out_sel_a,   (c - 1) % 4);
            end
            for (int w = 0; w < 4; w++) rd[w*32 +: 32] = 32'h100 * c + w;
            applyStimulus(4'hf, 4'hf, rd, 1'b1, 1'b1, 1'b1, 8'(8'h11 * (c + 1)), 1'b1);
        end

        reset_done = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            compareOutputs();
            if (!reset_done && ((c >= 200 && m_owner[1] >= 0 && m_valid[1]) || c == 599)) begin
                reset_done = 1'b1;
                doReset();
            end else begin
                for (int w = 0; w < 4; w++) begin
                    rd[w*32 +: 32] = $urandom;
                    rl[w] = ($urandom_range(2) == 0);
                end
                applyStimulus(4'($urandom), rl, rd, ($urandom_range(3) != 0),
                              1'($urandom), ($urandom_range(2) == 0), 8'($urandom),
                              ($urandom_range(3) != 0));
            end
        end

        @(negedge clk);
        compareOutputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
